// File: rtl/bp_fe_mem_sched.sv
// Front-end memory command scheduler: arbitrates fence, I-TLB fill and fetch
// onto one mem_cmd channel, tracks the 2-stage fetch pipeline and replays misses.
module bp_fe_mem_sched #(
  parameter int vaddr_width_p = 39,
  parameter int vtag_width_p  = 27,
  parameter int entry_width_p = 40
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_vaddr_i,
  output logic                     fetch_yumi_o,
  input  logic                     fill_v_i,
  input  logic [vtag_width_p-1:0]  fill_vtag_i,
  input  logic [entry_width_p-1:0] fill_entry_i,
  output logic                     fill_ready_o,
  input  logic                     fence_v_i,
  input  logic                     redirect_v_i,
  input  logic                     cache_req_complete_i,
  output logic                     mem_cmd_v_o,
  output logic [1:0]               mem_cmd_op_o,
  output logic [vaddr_width_p-1:0] mem_cmd_vaddr_o,
  output logic [vtag_width_p-1:0]  mem_cmd_vtag_o,
  output logic [entry_width_p-1:0] mem_cmd_entry_o,
  input  logic                     mem_cmd_yumi_i,
  output logic                     mem_poison_o,
  input  logic                     mem_resp_v_i,
  input  logic                     mem_resp_icache_miss_i,
  input  logic                     mem_resp_itlb_miss_i,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    e_run       = 2'd0,
    e_wait_fill = 2'd1,
    e_wait_miss = 2'd2
  } state_e;

  localparam logic [1:0] OpFetch = 2'd0;
  localparam logic [1:0] OpFill  = 2'd1;
  localparam logic [1:0] OpFence = 2'd2;

  state_e                   state_q, state_d;
  logic                     fencePend_q, fencePend_d;
  logic                     fillPend_q, fillPend_d;
  logic [vtag_width_p-1:0]  fillVtag_q, fillVtag_d;
  logic [entry_width_p-1:0] fillEntry_q, fillEntry_d;
  logic                     replayV_q, replayV_d;
  logic [vaddr_width_p-1:0] replayVaddr_q, replayVaddr_d;
  logic                     vR_q, vR_d;
  logic [vaddr_width_p-1:0] vaddrR_q, vaddrR_d;
  logic                     vRR_q, vRR_d;
  logic [vaddr_width_p-1:0] vaddrRR_q, vaddrRR_d;
  logic                     busy_q, busy_d;

  logic inRun, replayElig, fetchElig;
  logic selFence, selFill, selReplay, selFetch;
  logic fenceYumi, fillYumi, replayYumi, fetchYumi;
  logic missNow, poison;

  // Replay is also held off during a redirect so a wrong-path address never
  // enters stage 1; the fetch source is masked during reset so outputs drop at once.
  always_comb begin
    inRun      = (state_q == e_run);
    replayElig = replayV_q & inRun & ~redirect_v_i;
    fetchElig  = fetch_v_i & inRun & ~redirect_v_i & ~reset_i;
    selFence   = fencePend_q;
    selFill    = ~fencePend_q & fillPend_q;
    selReplay  = ~fencePend_q & ~fillPend_q & replayElig;
    selFetch   = ~fencePend_q & ~fillPend_q & ~replayElig & fetchElig;
    fenceYumi  = mem_cmd_yumi_i & selFence;
    fillYumi   = mem_cmd_yumi_i & selFill;
    replayYumi = mem_cmd_yumi_i & selReplay;
    fetchYumi  = mem_cmd_yumi_i & selFetch;
    missNow    = inRun & mem_resp_v_i & vRR_q & ~redirect_v_i
               & (mem_resp_icache_miss_i | mem_resp_itlb_miss_i);
    poison     = vR_q & (redirect_v_i | fenceYumi | fillYumi | missNow);
  end

  always_comb begin
    mem_cmd_v_o     = selFence | selFill | selReplay | selFetch;
    mem_cmd_op_o    = OpFetch;
    mem_cmd_vaddr_o = '0;
    mem_cmd_vtag_o  = '0;
    mem_cmd_entry_o = '0;
    if (selFence) begin
      mem_cmd_op_o = OpFence;
    end else if (selFill) begin
      mem_cmd_op_o    = OpFill;
      mem_cmd_vtag_o  = fillVtag_q;
      mem_cmd_entry_o = fillEntry_q;
    end else if (selReplay) begin
      mem_cmd_vaddr_o = replayVaddr_q;
    end else if (selFetch) begin
      mem_cmd_vaddr_o = fetch_vaddr_i;
    end
  end

  assign fetch_yumi_o = fetchYumi;
  assign fill_ready_o = ~fillPend_q;
  assign mem_poison_o = poison;
  assign busy_o       = busy_q;

  always_comb begin
    state_d       = state_q;
    fencePend_d   = (fencePend_q & ~fenceYumi) | fence_v_i;
    fillPend_d    = fillPend_q;
    fillVtag_d    = fillVtag_q;
    fillEntry_d   = fillEntry_q;
    replayV_d     = replayV_q;
    replayVaddr_d = replayVaddr_q;
    vR_d          = replayYumi | fetchYumi;
    vaddrR_d      = vaddrR_q;
    vRR_d         = vR_q & ~poison;
    vaddrRR_d     = vaddrR_q;

    if (fill_v_i & ~fillPend_q) begin
      fillPend_d  = 1'b1;
      fillVtag_d  = fill_vtag_i;
      fillEntry_d = fill_entry_i;
    end else if (fillYumi) begin
      fillPend_d = 1'b0;
    end

    if (replayYumi) begin
      vaddrR_d = replayVaddr_q;
    end else if (fetchYumi) begin
      vaddrR_d = fetch_vaddr_i;
    end

    if (replayYumi) begin
      replayV_d = 1'b0;
    end
    if (missNow) begin
      replayV_d     = 1'b1;
      replayVaddr_d = vaddrRR_q;
    end
    if (redirect_v_i) begin
      replayV_d = 1'b0;
    end

    case (state_q)
      e_run: begin
        if (missNow) begin
          state_d = mem_resp_itlb_miss_i ? e_wait_fill : e_wait_miss;
        end
      end
      e_wait_fill: begin
        if (redirect_v_i | fillYumi) begin
          state_d = e_run;
        end
      end
      e_wait_miss: begin
        if (redirect_v_i | cache_req_complete_i) begin
          state_d = e_run;
        end
      end
      default: state_d = e_run;
    endcase

    busy_d = (state_d != e_run) | fillPend_d | fencePend_d | replayV_d | vR_d | vRR_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= e_run;
      fencePend_q   <= 1'b0;
      fillPend_q    <= 1'b0;
      fillVtag_q    <= '0;
      fillEntry_q   <= '0;
      replayV_q     <= 1'b0;
      replayVaddr_q <= '0;
      vR_q          <= 1'b0;
      vaddrR_q      <= '0;
      vRR_q         <= 1'b0;
      vaddrRR_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fencePend_q   <= fencePend_d;
      fillPend_q    <= fillPend_d;
      fillVtag_q    <= fillVtag_d;
      fillEntry_q   <= fillEntry_d;
      replayV_q     <= replayV_d;
      replayVaddr_q <= replayVaddr_d;
      vR_q          <= vR_d;
      vaddrR_q      <= vaddrR_d;
      vRR_q         <= vRR_d;
      vaddrRR_q     <= vaddrRR_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_mem_sched.sv
// Self-checking bench for bp_fe_mem_sched: per-cycle vector table plus a
// scoreboard of issued commands, and a hand-written hold/async-reset sequence.
module tb_bp_fe_mem_sched;

  localparam int VW = 39;
  localparam int TW = 27;
  localparam int EW = 40;

  logic          clk;
  logic          reset_i;
  logic          fetch_v_i;
  logic [VW-1:0] fetch_vaddr_i;
  logic          fetch_yumi_o;
  logic          fill_v_i;
  logic [TW-1:0] fill_vtag_i;
  logic [EW-1:0] fill_entry_i;
  logic          fill_ready_o;
  logic          fence_v_i;
  logic          redirect_v_i;
  logic          cache_req_complete_i;
  logic          mem_cmd_v_o;
  logic [1:0]    mem_cmd_op_o;
  logic [VW-1:0] mem_cmd_vaddr_o;
  logic [TW-1:0] mem_cmd_vtag_o;
  logic [EW-1:0] mem_cmd_entry_o;
  logic          mem_cmd_yumi_i;
  logic          mem_poison_o;
  logic          mem_resp_v_i;
  logic          mem_resp_icache_miss_i;
  logic          mem_resp_itlb_miss_i;
  logic          busy_o;

  bp_fe_mem_sched #(.vaddr_width_p(VW), .vtag_width_p(TW), .entry_width_p(EW)) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .fetch_v_i             (fetch_v_i),
    .fetch_vaddr_i         (fetch_vaddr_i),
    .fetch_yumi_o          (fetch_yumi_o),
    .fill_v_i              (fill_v_i),
    .fill_vtag_i           (fill_vtag_i),
    .fill_entry_i          (fill_entry_i),
    .fill_ready_o          (fill_ready_o),
    .fence_v_i             (fence_v_i),
    .redirect_v_i          (redirect_v_i),
    .cache_req_complete_i  (cache_req_complete_i),
    .mem_cmd_v_o           (mem_cmd_v_o),
    .mem_cmd_op_o          (mem_cmd_op_o),
    .mem_cmd_vaddr_o       (mem_cmd_vaddr_o),
    .mem_cmd_vtag_o        (mem_cmd_vtag_o),
    .mem_cmd_entry_o       (mem_cmd_entry_o),
    .mem_cmd_yumi_i        (mem_cmd_yumi_i),
    .mem_poison_o          (mem_poison_o),
    .mem_resp_v_i          (mem_resp_v_i),
    .mem_resp_icache_miss_i(mem_resp_icache_miss_i),
    .mem_resp_itlb_miss_i  (mem_resp_itlb_miss_i),
    .busy_o                (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          fetchV;
    logic [VW-1:0] fetchVaddr;
    logic          fillV;
    logic [TW-1:0] fillVtag;
    logic          fenceV;
    logic          redirect;
    logic          done;
    logic          yumi;
    logic          respV;
    logic          icMiss;
    logic          itlbMiss;
    logic          expV;
    logic [1:0]    expOp;
    logic [VW-1:0] expVaddr;
    logic [TW-1:0] expVtag;
    logic          expFy;
    logic          expPoison;
    logic          expReady;
    logic [1:0]    expBusy;
  } vec_t;

  typedef struct {
    logic [1:0]    op;
    logic [VW-1:0] vaddr;
    logic [TW-1:0] vtag;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQ[$];
  sb_t  sbHead;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [EW-1:0] entryOf(logic [TW-1:0] t);
    return {~t[12:0], t};
  endfunction

  function automatic vec_t mkRow(
    logic fv, logic [VW-1:0] fa, logic flv, logic [TW-1:0] tag, logic fnv,
    logic rd, logic dn, logic y, logic rv, logic icm, logic itm,
    logic eV, logic [1:0] eOp, logic [VW-1:0] eA, logic [TW-1:0] eT,
    logic eFy, logic eP, logic eR, logic [1:0] eB);
    vec_t v;
    v.fetchV = fv; v.fetchVaddr = fa; v.fillV = flv; v.fillVtag = tag;
    v.fenceV = fnv; v.redirect = rd; v.done = dn; v.yumi = y;
    v.respV = rv; v.icMiss = icm; v.itlbMiss = itm;
    v.expV = eV; v.expOp = eOp; v.expVaddr = eA; v.expVtag = eT;
    v.expFy = eFy; v.expPoison = eP; v.expReady = eR; v.expBusy = eB;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    fetch_v_i            = v.fetchV;
    fetch_vaddr_i        = v.fetchVaddr;
    fill_v_i             = v.fillV;
    fill_vtag_i          = v.fillVtag;
    fill_entry_i         = entryOf(v.fillVtag);
    fence_v_i            = v.fenceV;
    redirect_v_i         = v.redirect;
    cache_req_complete_i = v.done;
    mem_cmd_yumi_i       = v.yumi;
    mem_resp_v_i         = v.respV;
    mem_resp_icache_miss_i = v.icMiss;
    mem_resp_itlb_miss_i = v.itlbMiss;
    if (v.yumi && v.expV) begin
      e.op = v.expOp; e.vaddr = v.expVaddr; e.vtag = v.expVtag;
      sbQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, " cmd_v"}, 64'(mem_cmd_v_o), 64'(v.expV));
    if (v.expV) begin
      checkVal({tag, " op"}, 64'(mem_cmd_op_o), 64'(v.expOp));
      if (v.expOp == 2'd0) checkVal({tag, " vaddr"}, 64'(mem_cmd_vaddr_o), 64'(v.expVaddr));
      if (v.expOp == 2'd1) begin
        checkVal({tag, " vtag"}, 64'(mem_cmd_vtag_o), 64'(v.expVtag));
        checkVal({tag, " entry"}, 64'(mem_cmd_entry_o), 64'(entryOf(v.expVtag)));
      end
    end
    checkVal({tag, " fetch_yumi"}, 64'(fetch_yumi_o), 64'(v.expFy));
    checkVal({tag, " poison"}, 64'(mem_poison_o), 64'(v.expPoison));
    checkVal({tag, " fill_ready"}, 64'(fill_ready_o), 64'(v.expReady));
    if (v.expBusy != 2'd2) checkVal({tag, " busy"}, 64'(busy_o), 64'(v.expBusy[0]));
  endtask

  task automatic checkZeroPayload(input string tag);
    checkVal({tag, " op0"}, 64'(mem_cmd_op_o), 64'd0);
    checkVal({tag, " vaddr0"}, 64'(mem_cmd_vaddr_o), 64'd0);
    checkVal({tag, " vtag0"}, 64'(mem_cmd_vtag_o), 64'd0);
    checkVal({tag, " entry0"}, 64'(mem_cmd_entry_o), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset_i && mem_cmd_v_o && mem_cmd_yumi_i) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL sb_unexpected: got op=%0d vaddr=%0h expected no command",
                 mem_cmd_op_o, mem_cmd_vaddr_o);
      end else begin
        sbHead = sbQ.pop_front();
        checkVal("sb op", 64'(mem_cmd_op_o), 64'(sbHead.op));
        if (sbHead.op == 2'd0) checkVal("sb vaddr", 64'(mem_cmd_vaddr_o), 64'(sbHead.vaddr));
        if (sbHead.op == 2'd1) checkVal("sb vtag", 64'(mem_cmd_vtag_o), 64'(sbHead.vtag));
      end
    end
  end

  initial begin
    vec_t idle, v;

    //            fv fa           flv tag   fnv rd dn y rv ic it | eV op eA           eT    fy p  r  b
    vecs.push_back(mkRow(1,'h8000_0000,0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h8000_0000,'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // fence, fill and fetch arrive together; issue order fence, fill, fetch
    vecs.push_back(mkRow(1,'h3000,     1,'h12, 1, 0, 0, 0, 0, 0, 0,  1, 0,'h3000,     'h00, 0, 0, 1, 0));
    vecs.push_back(mkRow(1,'h3000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 2,'h0,        'h00, 0, 0, 0, 1));
    vecs.push_back(mkRow(1,'h3000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 1,'h0,        'h12, 0, 0, 0, 1));
    vecs.push_back(mkRow(1,'h3000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h3000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // icache miss on 0x1000 with 0x1004 in stage 1, then replay
    vecs.push_back(mkRow(1,'h1000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h1000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(1,'h1004,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h1004,     'h00, 1, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 1, 1, 0,  0, 0,'h0,        'h00, 0, 1, 1, 1));
    vecs.push_back(mkRow(1,'h1008,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h1008,     0,'h00, 0, 0, 1, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h1008,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h1000,     'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h1008,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h1008,     'h00, 1, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 1, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 1, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // itlb miss (both miss bits set) on 0x2000, fill resumes, replay
    vecs.push_back(mkRow(1,'h2000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h2000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 1, 1, 1,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h2004,     1,'h33, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h2004,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 1,'h0,        'h33, 0, 0, 0, 1));
    vecs.push_back(mkRow(1,'h2004,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h2000,     'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(1,'h2004,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h2004,     'h00, 1, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // redirect during e_wait_miss with stage 1 valid drops the replay
    vecs.push_back(mkRow(1,'h4000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h4000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(1,'h4004,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h4004,     'h00, 1, 0, 1, 1));
    vecs.push_back(mkRow(1,'h4008,     0,'h00, 0, 0, 0, 1, 1, 1, 0,  1, 0,'h4008,     'h00, 1, 1, 1, 1));
    vecs.push_back(mkRow(1,'h8000,     0,'h00, 0, 1, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 1, 1, 1));
    vecs.push_back(mkRow(1,'h8000,     0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h8000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // fill yumi poisons stage 1; the poisoned fetch never reaches stage 2
    vecs.push_back(mkRow(1,'h6000,     1,'h44, 0, 0, 0, 1, 0, 0, 0,  1, 0,'h6000,     'h00, 1, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 1,'h0,        'h44, 0, 1, 0, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // repeated fence pulse merges into one fence command
    vecs.push_back(mkRow(0,'h0,        0,'h00, 1, 0, 0, 0, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 1, 0, 0, 0, 0, 0, 0,  1, 2,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  1, 2,'h0,        'h00, 0, 0, 1, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    // a fill offered in the cycle its predecessor is consumed is refused
    vecs.push_back(mkRow(0,'h0,        1,'h55, 0, 0, 0, 0, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));
    vecs.push_back(mkRow(0,'h0,        1,'h66, 0, 0, 0, 1, 0, 0, 0,  1, 1,'h0,        'h55, 0, 0, 0, 1));
    vecs.push_back(mkRow(0,'h0,        0,'h00, 0, 0, 0, 1, 0, 0, 0,  0, 0,'h0,        'h00, 0, 0, 1, 0));

    idle = mkRow(0,'h0,0,'h0,0,0,0,0,0,0,0, 0,0,'h0,'h0,0,0,1,0);
    reset_i = 1'b1;
    applyStimulus(idle);
    @(negedge clk);
    checkOutput(idle, "reset");
    checkZeroPayload("reset");
    @(posedge clk); #1;
    reset_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], $sformatf("r%0d", i));
      @(posedge clk); #1;
    end

    // Hold yumi low: the fetch payload must stay put, then a fill preempts it
    v = mkRow(1,'h5000,0,'h0,0,0,0,0,0,0,0, 1,0,'h5000,'h0,0,0,1,0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(v);
      @(negedge clk);
      checkOutput(v, $sformatf("hold%0d", c));
      @(posedge clk); #1;
    end
    v = mkRow(1,'h5000,1,'h77,0,0,0,0,0,0,0, 1,0,'h5000,'h0,0,0,1,0);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, "hold_fill_in");
    @(posedge clk); #1;
    v = mkRow(1,'h5000,0,'h0,0,0,0,0,0,0,0, 1,1,'h0,'h77,0,0,0,1);
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, "hold_fill_sel");

    // Asynchronous reset mid-cycle with the fetch request still asserted
    #2 reset_i = 1'b1;
    #1;
    v = mkRow(1,'h5000,0,'h0,0,0,0,0,0,0,0, 0,0,'h0,'h0,0,0,1,0);
    checkOutput(v, "async_reset");
    checkZeroPayload("async_reset");
    @(posedge clk); #1;
    applyStimulus(idle);
    reset_i = 1'b0;
    @(negedge clk);
    checkOutput(idle, "post_reset");
    @(posedge clk); #1;

    checkVal("sb_drain", 64'(sbQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
